// File: rtl/sipo_pkg.sv
// Shared definitions for the serial receive path (matches the PISO transmit side).
package sipo_pkg;

    // Default word length, shared with the 4-bit serializer.
    localparam int unsigned SIPO_WIDTH = 4;

    // The serializer shifts right and emits the LSB first.
    localparam bit LSB_FIRST = 1'b1;

    // Receiver framing state: no partial word, or a partial word in progress.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/sipo_out_slot.sv
// Single-entry output register with valid/ready handshake and overrun detection.
// A loaded word is held stable until accepted; a load arriving while the slot is
// occupied and not being drained is dropped and reported with a one-cycle pulse.
module sipo_out_slot #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             free;

    // Next slot contents: accept a new word if empty or draining this cycle.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        free      = ~valid_q | ready_i;
        if (load_i && free) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end else begin
            if (load_i) begin
                overrun_d = 1'b1;
            end
            if (valid_q && ready_i) begin
                valid_d = 1'b0;
            end
        end
    end

    // Slot registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: assembles WIDTH qualified serial bits (LSB
// first) into a word and hands it to a single-entry valid/ready output slot.
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = SIPO_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             si,
    input  logic             si_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    input  logic             po_ready,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] word;
    logic             word_done;

    // Incoming bit lands at the MSB end so the first bit ends up in the LSB.
    assign word = LSB_FIRST ? {si, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], si};

    // Framing: clear beats a same-cycle bit; the last bit wraps the counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        word_done = 1'b0;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
        end else if (si_valid) begin
            shreg_d = word;
            if (cnt_q == LAST_BIT) begin
                state_d   = IDLE;
                cnt_d     = '0;
                word_done = 1'b1;
            end else begin
                state_d = SHIFT;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    // Shift register, bit counter and state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    assign busy    = (state_q == SHIFT);
    assign bit_cnt = cnt_q;

    sipo_out_slot #(
        .WIDTH (WIDTH)
    ) u_slot (
        .clk_i     (clk),
        .reset_i   (reset),
        .load_i    (word_done),
        .data_i    (word),
        .ready_i   (po_ready),
        .data_o    (po),
        .valid_o   (po_valid),
        .overrun_o (overrun)
    );

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx (WIDTH=4): vector table, hand-written corner sequences and
// randomized traffic compared against a bit-queue reference model.
module tb_sipo_rx;

    localparam int W  = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          si = 1'b0;
    logic          si_valid = 1'b0;
    logic          clear = 1'b0;
    logic          po_ready = 1'b0;
    logic [W-1:0]  po;
    logic          po_valid;
    logic          busy;
    logic [CW-1:0] bit_cnt;
    logic          overrun;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .si       (si),
        .si_valid (si_valid),
        .clear    (clear),
        .po       (po),
        .po_valid (po_valid),
        .po_ready (po_ready),
        .busy     (busy),
        .bit_cnt  (bit_cnt),
        .overrun  (overrun)
    );

    // Reference model: received bits kept in arrival order, word built arithmetically.
    bit      mbits[$];
    int      m_po = 0;
    bit      m_valid = 1'b0;
    bit      m_ovr = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit done;
        bit free;
        int w;
        done = 1'b0;
        w    = 0;
        if (reset) begin
            mbits.delete();
            m_po    = 0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end else begin
            free = !m_valid || po_ready;
            if (clear) begin
                mbits.delete();
            end else if (si_valid) begin
                mbits.push_back(si);
                if (mbits.size() == W) begin
                    for (int i = 0; i < W; i++) w += int'(mbits[i]) * (1 << i);
                    mbits.delete();
                    done = 1'b1;
                end
            end
            m_ovr = done && !free;
            if (done && free) begin
                m_po    = w;
                m_valid = 1'b1;
            end else if (m_valid && po_ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    // Advance one clock with current inputs and compare every output to the model.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        chk("m_po",      int'(po),       m_po);
        chk("m_valid",   int'(po_valid), int'(m_valid));
        chk("m_overrun", int'(overrun),  int'(m_ovr));
        chk("m_bit_cnt", int'(bit_cnt),  mbits.size());
        chk("m_busy",    int'(busy),     int'(mbits.size() != 0));
    endtask

    task automatic drive(input bit r, input bit d, input bit v, input bit c, input bit rdy);
        reset = r; si = d; si_valid = v; clear = c; po_ready = rdy;
    endtask

    // Send one word LSB first on consecutive cycles; ready held during all bits
    // except that the last bit uses last_rdy.
    task automatic send_word(input logic [W-1:0] w, input bit rdy, input bit last_rdy);
        for (int i = 0; i < W; i++) begin
            drive(1'b0, w[i], 1'b1, 1'b0, (i == W-1) ? last_rdy : rdy);
            step();
        end
    endtask

    typedef struct {
        bit       r, d, v, c, rdy;
        logic [3:0] e_po;
        bit       e_valid;
        int       e_cnt;
        bit       e_ovr;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vec_t t;
        // reset, then 1,0,1,1 contiguous -> 4'hD; ready drains it
        vecs.push_back('{1,0,0,0,0, 4'h0,0,0,0});
        vecs.push_back('{0,1,1,0,0, 4'h0,0,1,0});
        vecs.push_back('{0,0,1,0,0, 4'h0,0,2,0});
        vecs.push_back('{0,1,1,0,0, 4'h0,0,3,0});
        vecs.push_back('{0,1,1,0,0, 4'hD,1,0,0});
        vecs.push_back('{0,0,0,0,1, 4'hD,0,0,0});
        // same word with gaps between bits; count holds through gaps
        vecs.push_back('{0,1,1,0,0, 4'hD,0,1,0});
        vecs.push_back('{0,0,0,0,0, 4'hD,0,1,0});
        vecs.push_back('{0,0,1,0,0, 4'hD,0,2,0});
        vecs.push_back('{0,1,0,0,0, 4'hD,0,2,0});
        vecs.push_back('{0,1,1,0,0, 4'hD,0,3,0});
        vecs.push_back('{0,0,0,0,0, 4'hD,0,3,0});
        vecs.push_back('{0,1,1,0,0, 4'hD,1,0,0});
        vecs.push_back('{0,0,0,0,1, 4'hD,0,0,0});

        for (int i = 0; i < vecs.size(); i++) begin
            t = vecs[i];
            drive(t.r, t.d, t.v, t.c, t.rdy);
            step();
            chk($sformatf("vec%0d_po", i),    int'(po),       int'(t.e_po));
            chk($sformatf("vec%0d_valid", i), int'(po_valid), int'(t.e_valid));
            chk($sformatf("vec%0d_cnt", i),   int'(bit_cnt),  t.e_cnt);
            chk($sformatf("vec%0d_busy", i),  int'(busy),     int'(t.e_cnt != 0));
            chk($sformatf("vec%0d_ovr", i),   int'(overrun),  int'(t.e_ovr));
        end

        // Overrun: A held while 5 completes with no ready
        send_word(4'hA, 1'b0, 1'b0);
        chk("ovr_first_po", int'(po), 'hA);
        chk("ovr_first_valid", int'(po_valid), 1);
        send_word(4'h5, 1'b0, 1'b0);
        chk("ovr_pulse", int'(overrun), 1);
        chk("ovr_po_kept", int'(po), 'hA);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("ovr_pulse_end", int'(overrun), 0);
        chk("ovr_still_valid", int'(po_valid), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk("ovr_drained", int'(po_valid), 0);

        // Back-to-back: 3 then C, ready only on C's completion cycle
        send_word(4'h3, 1'b0, 1'b0);
        chk("b2b_first", int'(po), 'h3);
        for (int i = 0; i < W; i++) begin
            drive(1'b0, i >= 2, 1'b1, 1'b0, i == W-1);
            step();
            chk("b2b_valid_hold", int'(po_valid), 1);
        end
        chk("b2b_second", int'(po), 'hC);
        chk("b2b_no_ovr", int'(overrun), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();

        // Clear after two bits discards them and the same-cycle bit
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); step();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); step();
        chk("clr_cnt_before", int'(bit_cnt), 2);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0); step();
        chk("clr_cnt_after", int'(bit_cnt), 0);
        chk("clr_busy_after", int'(busy), 0);
        send_word(4'h6, 1'b0, 1'b0);
        chk("clr_word", int'(po), 'h6);
        chk("clr_valid", int'(po_valid), 1);

        // Reset with a partial word and a pending output word
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            step();
        end
        chk("rst_pre_cnt", int'(bit_cnt), 3);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); step();
        chk("rst_po", int'(po), 0);
        chk("rst_valid", int'(po_valid), 0);
        chk("rst_cnt", int'(bit_cnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovr", int'(overrun), 0);
        send_word(4'h9, 1'b0, 1'b0);
        chk("rst_after_word", int'(po), 'h9);
        chk("rst_after_valid", int'(po_valid), 1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 199) == 0,
                  1'($urandom),
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 29) == 0,
                  $urandom_range(0, 2) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
